// File: rtl/bitty_fetch.sv
// Instruction fetch/sequencer feeding the Bitty datapath.
// Fetches 16-bit words over a req/valid handshake, pulses run, waits for done,
// then advances the PC. Stops on HALT_OPCODE or at an instruction boundary on stop.
// Optional build macro FETCH_TIMEOUT_EN adds a WAIT_MEM/EXEC watchdog that traps to ERROR.
module bitty_fetch #(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [15:0] HALT_OPCODE = 16'hFFFF,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              stop,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_valid,
  output logic [15:0]       instr,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       retired,
  output logic              err
);

  typedef enum logic [2:0] {
    StIdle, StReq, StWaitMem, StIssue, StExec, StHalt, StError
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       retired_q, retired_d;
  logic              stop_pend_q, stop_pend_d;
  logic              wait_timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  // Watchdog counter: zero on entry to a waiting state, counts while we stay there.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == StWaitMem) || (state_q == StExec))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the TIMEOUT-th waiting cycle so ERROR is entered exactly TIMEOUT cycles in.
  assign wait_timeout = (cnt_q == CntW'(TIMEOUT - 1));
  assign err          = (state_q == StError);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wait_timeout   = 1'b0;
  assign err            = 1'b0;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    retired_d   = retired_q;
    stop_pend_d = stop_pend_q;
    if (busy && stop) begin
      stop_pend_d = 1'b1;
    end
    unique case (state_q)
      StIdle, StHalt, StError: begin
        // start beats a same-cycle stop; stop is ignored here anyway
        if (start) begin
          state_d     = StReq;
          pc_d        = start_pc;
          stop_pend_d = 1'b0;
        end
      end
      StReq: state_d = StWaitMem;
      StWaitMem: begin
        if (mem_valid) begin
          instr_d = mem_rdata;
          state_d = (mem_rdata == HALT_OPCODE) ? StHalt : StIssue;
        end else if (wait_timeout) begin
          state_d = StError;
        end
      end
      StIssue: state_d = StExec;
      StExec: begin
        if (done) begin
          pc_d      = pc_q + 1'b1;
          retired_d = retired_q + 16'd1;
          // a stop arriving with done still counts for this boundary
          if (stop_pend_q || stop) begin
            state_d     = StIdle;
            stop_pend_d = 1'b0;
          end else begin
            state_d = StReq;
          end
        end else if (wait_timeout) begin
          state_d = StError;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      instr_q     <= '0;
      retired_q   <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      retired_q   <= retired_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign mem_req  = (state_q == StReq);
  assign mem_addr = pc_q;
  assign run      = (state_q == StIssue);
  assign busy     = (state_q == StReq) || (state_q == StWaitMem) ||
                    (state_q == StIssue) || (state_q == StExec);
  assign halted   = (state_q == StHalt);
  assign pc       = pc_q;
  assign instr    = instr_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_bitty_fetch.sv
// Self-checking bench for bitty_fetch: a program-level reference model fills
// expected fetch/issue queues, and a monitor pops them on every mem_req/run.
module tb_bitty_fetch;

  localparam logic [15:0] HALT = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset, start, stop, mem_valid, done;
  logic [7:0]  start_pc;
  logic [15:0] mem_rdata;
  logic        mem_req, run, busy, halted, err;
  logic [7:0]  mem_addr, pc;
  logic [15:0] instr, retired;

  bitty_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .start_pc (start_pc),
    .stop     (stop),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid),
    .instr    (instr),
    .run      (run),
    .done     (done),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted),
    .retired  (retired),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          run_seen = 0;
  int          req_seen = 0;
  logic [15:0] prog [256];
  logic [7:0]  exp_addr_q [$];
  logic [23:0] exp_run_q [$];
  logic [7:0]  model_pc;
  logic [15:0] model_ret;
  int          mem_lat_fix = 0;
  int          done_dly_fix = 0;
  bit          bitty_hold = 1'b0;
  bit          kick = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: walk the program from spc until the halt word.
  task automatic plan(input logic [7:0] spc);
    logic [7:0] a;
    a = spc;
    for (int i = 0; i < 256; i++) begin
      exp_addr_q.push_back(a);
      if (prog[a] == HALT) begin
        model_pc = a;
        break;
      end
      exp_run_q.push_back({a, prog[a]});
      model_ret = model_ret + 16'd1;
      a = a + 8'd1;
    end
  endtask

  task automatic do_start(input logic [7:0] p);
    @(negedge clk);
    start    = 1'b1;
    start_pc = p;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    for (int i = 0; i < 2000 && !halted; i++) @(negedge clk);
    check(name, {31'd0, halted}, 32'd1);
  endtask

  task automatic wait_run(input string name);
    for (int i = 0; i < 50 && !run; i++) @(negedge clk);
    check(name, {31'd0, run}, 32'd1);
  endtask

  task automatic chk_status(input string tag, input logic [7:0] epc, input logic [15:0] eret,
                            input logic eh, input logic eb, input logic ee);
    check({tag, "_pc"}, {24'd0, pc}, {24'd0, epc});
    check({tag, "_retired"}, {16'd0, retired}, {16'd0, eret});
    check({tag, "_halted"}, {31'd0, halted}, {31'd0, eh});
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, eb});
    check({tag, "_err"}, {31'd0, err}, {31'd0, ee});
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) prog[i] = HALT;
  endtask

  // Monitor: every fetch and issue must match the head of the expected queues.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mem_req) begin
          req_seen++;
          check("mem_req_expected", {31'd0, exp_addr_q.size() != 0}, 32'd1);
          if (exp_addr_q.size() != 0) check("mem_addr", {24'd0, mem_addr},
                                            {24'd0, exp_addr_q.pop_front()});
        end
        if (run) begin
          run_seen++;
          check("run_expected", {31'd0, exp_run_q.size() != 0}, 32'd1);
          if (exp_run_q.size() != 0) check("run_pc_instr", {8'd0, pc, instr},
                                           {8'd0, exp_run_q.pop_front()});
        end
      end
    end
  end

  // Program memory responder: 1..3 cycle latency, garbage data when not valid.
  initial begin
    int         lat;
    logic [7:0] a;
    mem_valid = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (reset && mem_req) begin
        a   = mem_addr;
        lat = (mem_lat_fix != 0) ? mem_lat_fix : int'($urandom_range(1, 3));
        repeat (lat - 1) @(posedge clk);
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_rdata = prog[a];
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_rdata = 16'($urandom);
      end
    end
  end

  // Bitty stand-in: done arrives d cycles after run; kick forces a stray done.
  initial begin
    int cnt;
    cnt  = 0;
    done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      done = 1'b0;
      if (!reset) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) done = 1'b1;
        end
        if (run && !bitty_hold) begin
          cnt = (done_dly_fix != 0) ? done_dly_fix : int'($urandom_range(1, 6));
        end
      end
      if (kick) done = 1'b1;
    end
  end

  initial begin
    int k;
    int r0;
    logic [7:0] spc;
    logic [7:0] a;
    reset    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    start_pc = 8'h0;
    model_ret = 16'd0;
    model_pc  = 8'h0;
    fill_halt();
    repeat (3) @(negedge clk);
    chk_status("reset", 8'h00, 16'd0, 1'b0, 1'b0, 1'b0);
    check("reset_instr", {16'd0, instr}, 32'd0);
    check("reset_run", {31'd0, run}, 32'd0);
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    reset = 1'b1;

    // Basic fetch/issue with fixed 1-cycle memory and 5-cycle execution.
    mem_lat_fix  = 1;
    done_dly_fix = 5;
    prog[8'h10]  = 16'h1234;
    plan(8'h10);
    @(negedge clk);
    start    = 1'b1;
    start_pc = 8'h10;
    @(negedge clk);
    start    = 1'b0;
    k = 1;
    while (!run && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("start_to_run_cycles", k, 3);
    check("issued_instr", {16'd0, instr}, 32'h1234);
    for (int i = 0; i < 30 && !mem_req; i++) @(negedge clk);
    check("second_req", {31'd0, mem_req}, 32'd1);
    chk_status("after_done", 8'h11, 16'd1, 1'b0, 1'b1, 1'b0);
    wait_halt("halt_t1");
    chk_status("t1_end", 8'h11, 16'd1, 1'b1, 1'b0, 1'b0);

    // Two instructions then halt opcode.
    mem_lat_fix  = 0;
    done_dly_fix = 0;
    prog[0] = 16'h0001;
    prog[1] = 16'h0002;
    prog[2] = HALT;
    r0 = run_seen;
    plan(8'h00);
    do_start(8'h00);
    wait_halt("halt_t2");
    check("t2_run_count", run_seen - r0, 2);
    chk_status("t2_end", 8'h02, model_ret, 1'b1, 1'b0, 1'b0);

    // stop during EXEC at 0x05: instruction retires, then idle with no further fetch.
    done_dly_fix = 4;
    prog[5] = 16'h0AAA;
    prog[6] = 16'h0BBB;
    exp_addr_q.push_back(8'h05);
    exp_run_q.push_back({8'h05, 16'h0AAA});
    model_ret = model_ret + 16'd1;
    r0 = req_seen;
    do_start(8'h05);
    wait_run("t3_run");
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (12) @(negedge clk);
    chk_status("t3_stopped", 8'h06, model_ret, 1'b0, 1'b0, 1'b0);
    check("t3_req_count", req_seen - r0, 1);
    done_dly_fix = 0;
    prog[8'h20] = 16'h0CCC;
    plan(8'h20);
    do_start(8'h20);
    wait_halt("halt_t3");
    chk_status("t3_resume", 8'h21, model_ret, 1'b1, 1'b0, 1'b0);

    // PC wrap from 0xFF to 0x00.
    prog[8'hFF] = 16'h0007;
    prog[0]     = HALT;
    plan(8'hFF);
    do_start(8'hFF);
    wait_halt("halt_wrap");
    chk_status("wrap", 8'h00, model_ret, 1'b1, 1'b0, 1'b0);

    // Randomized programs at random start addresses (may wrap).
    for (int t = 0; t < 20; t++) begin
      fill_halt();
      spc = 8'($urandom);
      k = $urandom_range(0, 6);
      for (int j = 0; j < k; j++) begin
        a = spc + 8'(j);
        prog[a] = 16'($urandom_range(0, 16'hFFFE));
      end
      if (($urandom & 1) == 1) stop = 1'b1;  // stop alongside start must be discarded
      plan(spc);
      do_start(spc);
      stop = 1'b0;
      wait_halt("halt_rand");
      chk_status("rand", model_pc, model_ret, 1'b1, 1'b0, 1'b0);
    end

    // Reset during EXEC, then a stray done right after release.
    fill_halt();
    bitty_hold = 1'b1;
    prog[8'h40] = 16'h1111;
    exp_addr_q.push_back(8'h40);
    exp_run_q.push_back({8'h40, 16'h1111});
    do_start(8'h40);
    wait_run("t5_run");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    kick  = 1'b1;
    r0 = run_seen;
    @(negedge clk);
    kick = 1'b0;
    repeat (5) @(negedge clk);
    model_ret = 16'd0;
    chk_status("mid_reset", 8'h00, 16'd0, 1'b0, 1'b0, 1'b0);
    check("mid_reset_instr", {16'd0, instr}, 32'd0);
    check("mid_reset_no_run", run_seen - r0, 0);

    // done withheld after run.
    prog[8'h50] = 16'h2222;
    exp_addr_q.push_back(8'h50);
    exp_run_q.push_back({8'h50, 16'h2222});
    do_start(8'h50);
    wait_run("t6_run");
`ifdef FETCH_TIMEOUT_EN
    repeat (64) @(negedge clk);
    chk_status("pre_timeout", 8'h50, 16'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_status("timeout", 8'h50, 16'd0, 1'b0, 1'b0, 1'b1);
    bitty_hold = 1'b0;
    plan(8'h60);
    do_start(8'h60);
    check("err_cleared", {31'd0, err}, 32'd0);
    wait_halt("halt_after_err");
    chk_status("after_err", 8'h60, 16'd0, 1'b1, 1'b0, 1'b0);
`else
    repeat (200) @(negedge clk);
    chk_status("no_timeout", 8'h50, 16'd0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bitty_hold = 1'b0;
    @(negedge clk);
`endif

    check("addr_queue_drained", exp_addr_q.size(), 0);
    check("run_queue_drained", exp_run_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
